isb_queue: RTL and testbench

//  Parametrised instruction stream buffer: a circular FIFO between fetch and decode.

---
 rtl/isb_pkg.sv | 19 +
 rtl/isb_queue_if.sv | 33 +++
 rtl/isb_ram.sv | 25 ++
 rtl/isb_queue.sv | 92 +++++++++
 tb/tb_isb_queue.sv | 134 +++++++++++++
 5 files changed

// File: rtl/isb_pkg.sv
// Shared types and width helpers for the instruction stream buffer.
// Optional empty-queue bypass is enabled by defining ISB_BYPASS_EN.
package isb_pkg;

  localparam int unsigned ISB_WIDTH_DEF = 16;
  localparam int unsigned ISB_DEPTH_DEF = 32;

  typedef logic [ISB_WIDTH_DEF-1:0] isb_word_t;

  function automatic int unsigned isb_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the counter can hold DEPTH itself.
  function automatic int unsigned isb_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/isb_queue_if.sv
// Fetch/decode handshake bundle for isb_queue; the buffer sits on the slave modport.
interface isb_queue_if
  import isb_pkg::*;
#(
  parameter int unsigned WIDTH = ISB_WIDTH_DEF,
  parameter int unsigned DEPTH = ISB_DEPTH_DEF
) ();

  localparam int unsigned CNT_W = isb_cnt_w(DEPTH);

  logic             flush;
  logic             pause;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;

  modport master (
    output flush, pause, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, empty, full
  );

  modport slave (
    input  flush, pause, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, empty, full
  );

endinterface

// File: rtl/isb_ram.sv
// Storage array for isb_queue: one synchronous write port, one asynchronous read port.
module isb_ram
  import isb_pkg::*;
#(
  parameter int unsigned WIDTH = ISB_WIDTH_DEF,
  parameter int unsigned DEPTH = ISB_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [isb_ptr_w(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic [isb_ptr_w(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]            rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // No reset: stale contents are masked by the occupancy count upstream.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/isb_queue.sv
// Instruction stream buffer: circular FIFO between fetch and decode with flush and pause.
// Define ISB_BYPASS_EN for a zero-latency path from in_data to out_data when drained.
module isb_queue
  import isb_pkg::*;
#(
  parameter int unsigned WIDTH = ISB_WIDTH_DEF,
  parameter int unsigned DEPTH = ISB_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  isb_queue_if.slave  bus
);

  localparam int unsigned PTR_W = isb_ptr_w(DEPTH);
  localparam int unsigned CNT_W = isb_cnt_w(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             empty_c, full_c;
  logic             byp_c, out_valid_c, in_ready_c;
  logic             push_c, pop_c, mem_pop_c, wr_c;
  logic [WIDTH-1:0] rd_data;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));

`ifdef ISB_BYPASS_EN
  assign byp_c = empty_c & bus.in_valid & ~bus.flush;
`else
  assign byp_c = 1'b0;
`endif

  assign in_ready_c  = ~full_c & ~bus.flush;
  assign out_valid_c = ~bus.flush & (~empty_c | byp_c);
  assign push_c      = bus.in_valid & in_ready_c;
  assign pop_c       = out_valid_c & bus.out_ready & ~bus.pause;

  // A pop while empty can only be a bypassed word: it never touches the array.
  assign mem_pop_c = pop_c & ~empty_c;
  assign wr_c      = push_c & ~(pop_c & empty_c);

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = !out_valid_c ? '0 : (empty_c ? bus.in_data : rd_data);
  assign bus.count     = count_q;
  assign bus.empty     = empty_c;
  assign bus.full      = full_c;

  isb_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_c),
    .waddr_i (tail_q),
    .wdata_i (bus.in_data),
    .raddr_i (head_q),
    .rdata_o (rd_data)
  );

  // Pointer and occupancy next state; flush overrides everything but reset.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (mem_pop_c) head_d = head_q + PTR_W'(1);
      if (wr_c)      tail_d = tail_q + PTR_W'(1);
      if (wr_c && !mem_pop_c)      count_d = count_q + CNT_W'(1);
      else if (!wr_c && mem_pop_c) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_isb_queue.sv
// Self-checking bench for isb_queue: directed scenarios plus random traffic against a queue model.
module tb_isb_queue;
  import isb_pkg::*;

  localparam int unsigned W = ISB_WIDTH_DEF;
  localparam int unsigned D = ISB_DEPTH_DEF;
`ifdef ISB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  isb_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();

  isb_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  isb_word_t mq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check outputs against the model, advance the model.
  task automatic cyc(input bit fl, input bit pa, input bit iv, input isb_word_t d,
                     input bit ordy, input string tag);
    bit e, byp, ov, ir, pop, push;
    isb_word_t od;
    bus.flush = fl; bus.pause = pa; bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
    #3;
    e   = (mq.size() == 0);
    ir  = (mq.size() < int'(D)) && !fl;
    byp = BYP && e && iv && !fl;
    ov  = !fl && (!e || byp);
    od  = !ov ? 16'h0 : (!e ? mq[0] : d);
    chk({tag, ".count"},     32'(bus.count),     32'(mq.size()));
    chk({tag, ".empty"},     32'(bus.empty),     32'(e));
    chk({tag, ".full"},      32'(bus.full),      32'(mq.size() == int'(D)));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(od));
    pop  = ov && ordy && !pa;
    push = iv && ir;
    if (fl) mq.delete();
    else begin
      if (pop && !e) void'(mq.pop_front());
      if (push && !(pop && e)) mq.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.flush = 1'b0; bus.pause = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
  endtask

  initial begin
    int guard;
    // 1: reset state
    do_reset(2);
    cyc(0, 0, 0, 16'h0, 0, "t1.idle");

    // 2: fill to full, then a refused push
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, 16'h1111 + 16'(i), 0, "t2.fill");
    chk("t2.full_flag", 32'(bus.full), 32'd1);
    cyc(0, 0, 1, 16'hDEAD, 0, "t2.refused");
    chk("t2.count_held", 32'(bus.count), 32'd32);

    // 3: drain in order across wrap, then streaming push/pop
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 16'h0, 1, "t3.drain");
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, 16'h3000 + 16'(i), 1, "t3.stream");
    guard = 0;
    while (mq.size() > 0 && guard < 64) begin
      cyc(0, 0, 0, 16'h0, 1, "t3.tail");
      guard++;
    end
    chk("t3.empty_end", 32'(bus.empty), 32'd1);

    // 4: steady occupancy 5, then pause
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 16'h4000 + 16'(i), 0, "t4.fill");
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 16'h4100 + 16'(i), 1, "t4.pp");
    chk("t4.count5", 32'(bus.count), 32'd5);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 16'h0, 1, "t4.pause");

    // 5: flush with a competing push
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 16'h5000 + 16'(i), 0, "t5.fill");
    cyc(1, 0, 1, 16'hBEEF, 0, "t5.flush");
    chk("t5.count0", 32'(bus.count), 32'd0);
    chk("t5.nobeef", 32'(bus.out_data == 16'hBEEF), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 16'h0, 1, "t5.after");

    // 6: word into an empty buffer, consumer ready, then paused
    do_reset(1);
    cyc(0, 0, 1, 16'hA5A5, 1, "t6.byp");
    cyc(0, 0, 0, 16'h0, 1, "t6.next");
    cyc(0, 0, 0, 16'h0, 1, "t6.idle");
    chk("t6.count0", 32'(bus.count), 32'd0);
    cyc(0, 1, 1, 16'hA5A5, 1, "t6.paused");
    chk("t6.count1", 32'(bus.count), 32'd1);
    cyc(0, 0, 0, 16'h0, 1, "t6.release");

    // Random traffic: fill-biased phase, mid-run reset, drain-biased phase
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 75,
          16'($urandom), $urandom_range(0, 99) < 35, "rnd.a");
    do_reset(1);
    cyc(0, 0, 0, 16'h0, 0, "rnd.rst");
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 45,
          16'($urandom), $urandom_range(0, 99) < 80, "rnd.b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
